// File: rtl/stream_to_vga_sync.sv
// stream_to_vga_sync: buffers a bursty RGB pixel stream and replays it under free-running VGA timing
module stream_to_vga_sync #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIXEL_DEPTH = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int PRIME_LEVEL = 640
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   sof_i,
  input  logic [PIXEL_DEPTH-1:0] input_R,
  input  logic [PIXEL_DEPTH-1:0] input_G,
  input  logic [PIXEL_DEPTH-1:0] input_B,
  output logic [PIXEL_DEPTH-1:0] VGA_R,
  output logic [PIXEL_DEPTH-1:0] VGA_G,
  output logic [PIXEL_DEPTH-1:0] VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic [12:0]            row,
  output logic [12:0]            col,
  output logic [ADDR_WIDTH:0]    fifo_level,
  output logic                   overflow_o,
  output logic                   underflow_o
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [12:0] H_ACT   = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT   = 13'(V_ACTIVE);
  localparam logic [12:0] H_TOTAL = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [12:0] V_TOTAL = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [12:0] HS_BEG  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END  = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LW-1:0] DEPTH     = LW'(2 ** ADDR_WIDTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;
  state_t state, state_nx;

  logic [3*PIXEL_DEPTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [12:0] h_cnt, v_cnt;
  logic active, h_end, v_end, frame_end, fifo_empty, fifo_full;
  logic push_ok, push, pop_req, pop, clear;

  // Timing decode and FIFO handshake; a pop on empty never bypasses a same-cycle push
  always_comb begin
    active     = h_cnt < H_ACT && v_cnt < V_ACT;
    h_end      = h_cnt == H_TOTAL - 13'd1;
    v_end      = v_cnt == V_TOTAL - 13'd1;
    frame_end  = h_end && v_end;
    fifo_empty = fifo_level == '0;
    fifo_full  = fifo_level == DEPTH;
    push_ok    = valid_i && ((state == IDLE && sof_i) || state == PRIME || state == RUN);
    pop_req    = state == RUN && active;
    pop        = pop_req && !fifo_empty;
    push       = push_ok && (!fifo_full || pop);
    clear      = state == FLUSH && frame_end;
  end

  // Next state: start on sof, run once primed, flush on starvation until the frame ends
  always_comb begin
    state_nx = state;
    if (state == IDLE && valid_i && sof_i) state_nx = PRIME;
    if (state == PRIME && fifo_level >= PRIME_LVL) state_nx = RUN;
    if (state == RUN && pop_req && fifo_empty) state_nx = FLUSH;
    if (state == FLUSH && frame_end) state_nx = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
  end

  // Raster counters: parked at the origin until the FIFO is primed
  always_ff @(posedge clk) begin
    if (reset || clear || state == IDLE || state == PRIME) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 13'd1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 13'd1;
    end
  end

  // Pixel storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {input_R, input_G, input_B};
  end

  // FIFO pointers and occupancy, emptied on reset and at the end of a flushed frame
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= wr_ptr + ADDR_WIDTH'(push);
      rd_ptr     <= rd_ptr + ADDR_WIDTH'(pop);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // Sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= overflow_o | (push_ok && fifo_full && !pop);
      underflow_o <= underflow_o | (pop_req && fifo_empty);
    end
  end

  // Registered video outputs, all one clock behind the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      row         <= '0;
      col         <= '0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= pop ? mem[rd_ptr] : '0;
      VGA_HS      <= !(h_cnt >= HS_BEG && h_cnt < HS_END);
      VGA_VS      <= !(v_cnt >= VS_BEG && v_cnt < VS_END);
      VGA_BLANK_N <= pop_req;
      row         <= v_cnt;
      col         <= h_cnt;
    end
  end
endmodule

// File: tb/tb_stream_to_vga_sync.sv
// tb_stream_to_vga_sync: directed checks of buffering, raster timing and error recovery
module tb_stream_to_vga_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;

  logic a_rst, a_v, a_sof, a_hs, a_vs, a_bn, a_ovf, a_unf;
  logic [7:0] a_ir, a_ig, a_ib, a_r, a_g, a_b;
  logic [12:0] a_row, a_col;
  logic [10:0] a_lvl;
  logic b_rst, b_v, b_sof, b_hs, b_vs, b_bn, b_ovf, b_unf;
  logic [7:0] b_ir, b_ig, b_ib, b_r, b_g, b_b;
  logic [12:0] b_row, b_col;
  logic [9:0] b_lvl;
  logic c_rst, c_v, c_sof, c_hs, c_vs, c_bn, c_ovf, c_unf;
  logic [7:0] c_ir, c_ig, c_ib, c_r, c_g, c_b;
  logic [12:0] c_row, c_col;
  logic [4:0] c_lvl;

  stream_to_vga_sync dut_a (
    .clk(clk), .reset(a_rst), .valid_i(a_v), .sof_i(a_sof),
    .input_R(a_ir), .input_G(a_ig), .input_B(a_ib),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn),
    .row(a_row), .col(a_col), .fifo_level(a_lvl), .overflow_o(a_ovf), .underflow_o(a_unf));

  stream_to_vga_sync #(
    .H_ACTIVE(27), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_WIDTH(9), .PRIME_LEVEL(27)
  ) dut_b (
    .clk(clk), .reset(b_rst), .valid_i(b_v), .sof_i(b_sof),
    .input_R(b_ir), .input_G(b_ig), .input_B(b_ib),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn),
    .row(b_row), .col(b_col), .fifo_level(b_lvl), .overflow_o(b_ovf), .underflow_o(b_unf));

  stream_to_vga_sync #(.ADDR_WIDTH(4), .PRIME_LEVEL(16)) dut_c (
    .clk(clk), .reset(c_rst), .valid_i(c_v), .sof_i(c_sof),
    .input_R(c_ir), .input_G(c_ig), .input_B(c_ib),
    .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_BLANK_N(c_bn),
    .row(c_row), .col(c_col), .fifo_level(c_lvl), .overflow_o(c_ovf), .underflow_o(c_unf));

  task automatic test_reset();
    {a_rst, b_rst, c_rst} = 3'b111;
    {a_v, a_sof, b_v, b_sof, c_v, c_sof} = '0;
    {a_ir, a_ig, a_ib, b_ir, b_ig, b_ib, c_ir, c_ig, c_ib} = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({a_r, a_g, a_b, a_hs, a_vs, a_bn, a_row, a_col, a_lvl, a_ovf, a_unf} !== {24'h0, 3'b110, 26'h0, 11'h0, 2'b00}) begin
      bad++; $display("FAIL reset_a got=%h want=%h", {a_r, a_g, a_b, a_hs, a_vs, a_bn, a_row, a_col, a_lvl, a_ovf, a_unf}, {24'h0, 3'b110, 26'h0, 11'h0, 2'b00});
    end
    total++;
    if ({b_r, b_g, b_b, b_hs, b_vs, b_bn, b_row, b_col, b_lvl, b_ovf, b_unf} !== {24'h0, 3'b110, 26'h0, 10'h0, 2'b00}) begin
      bad++; $display("FAIL reset_b got=%h want=%h", {b_r, b_g, b_b, b_hs, b_vs, b_bn, b_row, b_col, b_lvl, b_ovf, b_unf}, {24'h0, 3'b110, 26'h0, 10'h0, 2'b00});
    end
    total++;
    if ({c_r, c_g, c_b, c_hs, c_vs, c_bn, c_row, c_col, c_lvl, c_ovf, c_unf} !== {24'h0, 3'b110, 26'h0, 5'h0, 2'b00}) begin
      bad++; $display("FAIL reset_c got=%h want=%h", {c_r, c_g, c_b, c_hs, c_vs, c_bn, c_row, c_col, c_lvl, c_ovf, c_unf}, {24'h0, 3'b110, 26'h0, 5'h0, 2'b00});
    end
    {a_rst, b_rst, c_rst} = 3'b000;
  endtask

  task automatic test_ramp_underflow();
    int first = -1, line0 = -1, line = -1, hs_fall = -1, hs_w = -1, unf_at = -1, flush_bad = 0;
    bit seen300 = 0;
    logic prev_bn = 1'b0, prev_hs = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (a_bn && !prev_bn) begin
        if (line0 < 0) line0 = n;
        else if (line < 0) line = n - line0;
      end
      if (a_bn && first < 0) begin
        first = n; total++;
        if ({a_r, a_g, a_b, a_row, a_col} !== {16'h0, 8'h5A, 26'h0}) begin
          bad++; $display("FAIL first_pixel got=%h want=%h", {a_r, a_g, a_b, a_row, a_col}, {16'h0, 8'h5A, 26'h0});
        end
      end
      if (!a_hs && prev_hs) hs_fall = n;
      if (a_hs && !prev_hs && hs_w < 0 && hs_fall >= 0) hs_w = n - hs_fall;
      if (a_bn && a_row == 13'd1 && a_col == 13'd300) begin
        seen300 = 1; total++;
        if ({a_r, a_g, a_b} !== 24'h2C015A) begin
          bad++; $display("FAIL pixel_r1_c300 got=%h want=%h", {a_r, a_g, a_b}, 24'h2C015A);
        end
      end
      if (a_unf && unf_at < 0) begin
        unf_at = n; total++;
        if ({a_row, a_col, a_r, a_g, a_b} !== {13'd1, 13'd360, 24'h0}) begin
          bad++; $display("FAIL underflow_slot got=%h want=%h", {a_row, a_col, a_r, a_g, a_b}, {13'd1, 13'd360, 24'h0});
        end
      end else if (unf_at >= 0 && (a_bn || {a_r, a_g, a_b} != 24'h0)) flush_bad++;
      prev_bn = a_bn;
      prev_hs = a_hs;
      a_v = n < 1000; a_sof = n == 0;
      a_ir = 8'(n % 640); a_ig = 8'(n / 640); a_ib = 8'h5A;
      @(negedge clk);
    end
    total++; if (first != 642) begin bad++; $display("FAIL prime_latency got=%0d want=642", first); end
    total++; if (line != 800) begin bad++; $display("FAIL line_period got=%0d want=800", line); end
    total++; if (hs_w != 96) begin bad++; $display("FAIL hs_width got=%0d want=96", hs_w); end
    total++; if (!seen300) begin bad++; $display("FAIL pixel_r1_c300_seen got=0 want=1"); end
    total++; if (unf_at != 1802) begin bad++; $display("FAIL underflow_time got=%0d want=1802", unf_at); end
    total++; if (flush_bad != 0) begin bad++; $display("FAIL flush_blank got=%0d want=0", flush_bad); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL ramp_overflow got=%b want=0", a_ovf); end
  endtask

  task automatic test_rate();
    int n = 0, d = 0, err = 0, err_d = -1, vs_f0 = -1, vs_f1 = -1, vs_w = -1;
    logic [49:0] want, err_got = '0, err_want = '0;
    logic prev_vs = 1'b1;
    b_rst = 1; b_v = 0; b_sof = 0; @(negedge clk); b_rst = 0;
    for (int cyc = 0; cyc < 2000 && d < 648; cyc++) begin
      if (b_bn) begin
        want = {8'(d % 27), 8'(d % 216 / 27), 8'(8'h5A + d / 216), 13'(d % 216 / 27), 13'(d % 27)};
        if ({b_r, b_g, b_b, b_row, b_col} !== want) begin
          if (err == 0) begin err_d = d; err_got = {b_r, b_g, b_b, b_row, b_col}; err_want = want; end
          err++;
        end
        d++;
      end
      if (!b_vs && prev_vs) begin
        if (vs_f0 < 0) vs_f0 = cyc;
        else if (vs_f1 < 0) vs_f1 = cyc;
      end
      if (b_vs && !prev_vs && vs_w < 0 && vs_f0 >= 0) vs_w = cyc - vs_f0;
      prev_vs = b_vs;
      b_v = n < 648 && cyc % 10 != 9;
      b_sof = b_v && n % 216 == 0;
      b_ir = 8'(n % 27); b_ig = 8'(n % 216 / 27); b_ib = 8'(8'h5A + n / 216);
      if (b_v) n++;
      @(negedge clk);
    end
    total++; if (d != 648) begin bad++; $display("FAIL rate_pixel_count got=%0d want=648", d); end
    total++; if (err != 0) begin bad++; $display("FAIL rate_ramp count=%0d at d=%0d got=%h want=%h", err, err_d, err_got, err_want); end
    total++; if ({b_ovf, b_unf} !== 2'b00) begin bad++; $display("FAIL rate_flags got=%b want=00", {b_ovf, b_unf}); end
    total++; if (vs_f1 - vs_f0 != 330) begin bad++; $display("FAIL frame_period got=%0d want=330", vs_f1 - vs_f0); end
    total++; if (vs_w != 30) begin bad++; $display("FAIL vs_width got=%0d want=30", vs_w); end
  endtask

  task automatic test_presof();
    int lvl_bad = 0, first = -1;
    b_rst = 1; b_v = 0; b_sof = 0; @(negedge clk); b_rst = 0;
    for (int cyc = 0; cyc <= 50; cyc++) begin
      if (b_lvl !== '0) lvl_bad++;
      b_v = cyc < 50; b_sof = 0; {b_ir, b_ig, b_ib} = 24'hFFFFFF;
      @(negedge clk);
    end
    total++; if (lvl_bad != 0) begin bad++; $display("FAIL presof_level got=%0d want=0", lvl_bad); end
    for (int n = 0; n < 400 && first < 0; n++) begin
      if (b_bn) begin
        first = n; total++;
        if ({b_r, b_g, b_b, b_row, b_col} !== {16'h0, 8'h5A, 26'h0}) begin
          bad++; $display("FAIL presof_first got=%h want=%h", {b_r, b_g, b_b, b_row, b_col}, {16'h0, 8'h5A, 26'h0});
        end
      end
      b_v = n < 216; b_sof = n == 0;
      b_ir = 8'(n % 27); b_ig = 8'(n / 27); b_ib = 8'h5A;
      @(negedge clk);
    end
    total++; if (first != 29) begin bad++; $display("FAIL presof_latency got=%0d want=29", first); end
  endtask

  task automatic test_flush_idle();
    int unf_at = -1, hs_pulses = 0, flush_bad = 0, idle_bad = 0;
    logic prev_hs = 1'b1;
    b_rst = 1; b_v = 0; b_sof = 0; @(negedge clk); b_rst = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (b_unf && unf_at < 0) begin
        unf_at = cyc; total++;
        if ({b_row, b_col, b_r, b_g, b_b} !== {13'd1, 13'd13, 24'h0}) begin
          bad++; $display("FAIL flush_slot got=%h want=%h", {b_row, b_col, b_r, b_g, b_b}, {13'd1, 13'd13, 24'h0});
        end
      end else if (unf_at >= 0 && (b_bn || {b_r, b_g, b_b} != 24'h0)) flush_bad++;
      if (unf_at >= 0 && !b_hs && prev_hs) hs_pulses++;
      if (cyc >= 600 && {b_hs, b_vs, b_bn, b_lvl} !== {3'b110, 10'h0}) idle_bad++;
      prev_hs = b_hs;
      b_v = cyc < 40; b_sof = cyc == 0;
      b_ir = 8'(cyc % 27); b_ig = 8'(cyc / 27); b_ib = 8'h5A;
      @(negedge clk);
    end
    total++; if (unf_at != 72) begin bad++; $display("FAIL flush_time got=%0d want=72", unf_at); end
    total++; if (flush_bad != 0) begin bad++; $display("FAIL flush_blank_b got=%0d want=0", flush_bad); end
    total++; if (hs_pulses < 1) begin bad++; $display("FAIL flush_timing_runs got=%0d want>=1", hs_pulses); end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL idle_after_flush got=%0d want=0", idle_bad); end
    total++; if ({b_ovf, b_unf} !== 2'b01) begin bad++; $display("FAIL flush_flags got=%b want=01", {b_ovf, b_unf}); end
  endtask

  task automatic test_overflow_reset();
    bit hit = 0;
    int first = -1, err = 0, j = 0;
    c_rst = 1; c_v = 0; c_sof = 0; @(negedge clk); c_rst = 0;
    for (int cyc = 0; cyc < 1200 && !hit; cyc++) begin
      if (cyc == 16) begin
        total++; if ({c_lvl, c_ovf} !== {5'd16, 1'b0}) begin bad++; $display("FAIL ovf_before got=%h want=%h", {c_lvl, c_ovf}, {5'd16, 1'b0}); end
      end
      if (cyc == 17) begin
        total++; if ({c_lvl, c_ovf} !== {5'd16, 1'b1}) begin bad++; $display("FAIL ovf_17th got=%h want=%h", {c_lvl, c_ovf}, {5'd16, 1'b1}); end
      end
      if (cyc == 18) begin
        total++; if ({c_bn, c_r, c_row, c_col} !== {1'b1, 8'd1, 26'h0}) begin bad++; $display("FAIL ovf_first_pixel got=%h want=%h", {c_bn, c_r, c_row, c_col}, {1'b1, 8'd1, 26'h0}); end
      end
      if (cyc == 20) begin
        total++; if (c_lvl !== 5'd16) begin bad++; $display("FAIL full_push_pop got=%0d want=16", c_lvl); end
      end
      if (cyc == 34) begin
        total++; if ({c_bn, c_r} !== {1'b1, 8'd18}) begin bad++; $display("FAIL dropped_skip got=%h want=%h", {c_bn, c_r}, {1'b1, 8'd18}); end
      end
      if (c_bn && c_row == 13'd0 && c_col == 13'd320) begin
        hit = 1; c_rst = 1; c_v = 0; c_sof = 0;
      end else begin
        c_v = 1; c_sof = cyc == 0; c_ir = 8'(cyc + 1); c_ig = 8'hA0; c_ib = 8'h5A;
      end
      @(negedge clk);
    end
    total++;
    if (!hit || {c_r, c_g, c_b, c_hs, c_vs, c_bn, c_row, c_col, c_lvl, c_ovf, c_unf} !== {24'h0, 3'b110, 26'h0, 5'h0, 2'b00}) begin
      bad++; $display("FAIL midline_reset hit=%0d got=%h want=%h", hit, {c_r, c_g, c_b, c_hs, c_vs, c_bn, c_row, c_col, c_lvl, c_ovf, c_unf}, {24'h0, 3'b110, 26'h0, 5'h0, 2'b00});
    end
    c_rst = 0;
    for (int cyc = 0; cyc < 100 && j < 16; cyc++) begin
      if (c_bn) begin
        if (first < 0) first = cyc;
        if ({c_r, c_row, c_col} !== {8'(8'h40 + j), 13'd0, 13'(j)}) err++;
        j++;
      end
      c_v = 1; c_sof = cyc == 0; c_ir = 8'(8'h40 + cyc); c_ig = 8'hA0; c_ib = 8'h5A;
      @(negedge clk);
    end
    total++; if (first != 18) begin bad++; $display("FAIL restart_latency got=%0d want=18", first); end
    total++; if (j != 16 || err != 0) begin bad++; $display("FAIL restart_pixels got=%0d/%0d errs=%0d want=16/0", j, 16, err); end
  endtask

  initial begin
    test_reset();
    test_ramp_underflow();
    test_rate();
    test_presof();
    test_flush_idle();
    test_overflow_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
